// File: rtl/fpu_req_arbiter_if.sv
// Requester-side and FPU-side signal bundle for fpu_req_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface fpu_req_arbiter_if #(
    parameter int NumReq = 4,
    parameter int Width  = 32
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic                        flush_i;
    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq*3*Width-1:0]   req_operands_i;
    logic [NumReq*4-1:0]         req_op_i;
    logic [NumReq-1:0]           req_op_mod_i;
    logic [NumReq*3-1:0]         req_rnd_i;
    logic                        fpu_valid_o;
    logic                        fpu_ready_i;
    logic [3*Width-1:0]          fpu_operands_o;
    logic [3:0]                  fpu_op_o;
    logic                        fpu_op_mod_o;
    logic [2:0]                  fpu_rnd_o;
    logic [IdxW-1:0]             fpu_tag_o;
    logic                        fpu_flush_o;
    logic                        fpu_out_valid_i;
    logic                        fpu_out_ready_o;
    logic [Width-1:0]            fpu_result_i;
    logic [4:0]                  fpu_status_i;
    logic [IdxW-1:0]             fpu_tag_i;
    logic [NumReq-1:0]           rsp_valid_o;
    logic [NumReq-1:0]           rsp_ready_i;
    logic [Width-1:0]            rsp_result_o;
    logic [4:0]                  rsp_status_o;
    logic                        busy_o;

    modport slave (
        input  flush_i, req_valid_i, req_operands_i, req_op_i, req_op_mod_i, req_rnd_i,
               fpu_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i, rsp_ready_i,
        output req_ready_o, fpu_valid_o, fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_o,
               fpu_tag_o, fpu_flush_o, fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
               busy_o
    );

    modport master (
        output flush_i, req_valid_i, req_operands_i, req_op_i, req_op_mod_i, req_rnd_i,
               fpu_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i, rsp_ready_i,
        input  req_ready_o, fpu_valid_o, fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_o,
               fpu_tag_o, fpu_flush_o, fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
               busy_o
    );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin sharing of one FPU between NumReq requesters: tag-based result routing,
// grant lock while the FPU stalls, and a credit limit on in-flight operations.
module fpu_req_arbiter #(
    parameter int NumReq         = 4,
    parameter int Width          = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fpu_req_arbiter_if.slave    bus
);
    localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW   = $clog2(MaxOutstanding + 1);
    localparam int NumTag = 1 << IdxW;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic [IdxW-1:0]   lock_idx_q;
    logic [CntW-1:0]   inflight_q;
    logic [CntW-1:0]   inflight_d;

    logic [3*Width-1:0] ops_arr [NumReq];
    logic [3:0]         op_arr  [NumReq];
    logic [2:0]         rnd_arr [NumReq];
    logic [NumTag-1:0]  rsp_ready_ext;

    logic [IdxW-1:0] rr_idx, cand, grant, rr_next;
    logic            rr_found, grant_vld, credit_ok, issue_vld, issue_hs, rsp_hs;

    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_req
            assign ops_arr[gi] = bus.req_operands_i[gi*3*Width +: 3*Width];
            assign op_arr[gi]  = bus.req_op_i[gi*4 +: 4];
            assign rnd_arr[gi] = bus.req_rnd_i[gi*3 +: 3];
            assign bus.req_ready_o[gi] = issue_hs && (grant == IdxW'(gi));
            assign bus.rsp_valid_o[gi] = rst_ni && !bus.flush_i && bus.fpu_out_valid_i
                                         && (bus.fpu_tag_i == IdxW'(gi));
        end
        // Tags that name no requester are accepted and dropped so a bad tag cannot wedge the FPU.
        for (gi = 0; gi < NumTag; gi++) begin : g_tag
            if (gi < NumReq) begin : g_real
                assign rsp_ready_ext[gi] = bus.rsp_ready_i[gi];
            end else begin : g_spare
                assign rsp_ready_ext[gi] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        cand     = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = IdxW'((int'(rr_ptr_q) + k) % NumReq);
            if (!rr_found && bus.req_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign grant     = (state_q == HOLD) ? lock_idx_q : rr_idx;
    assign grant_vld = (state_q == HOLD) ? bus.req_valid_i[lock_idx_q] : rr_found;
    assign credit_ok = inflight_q < CntW'(MaxOutstanding);
    assign issue_vld = rst_ni && !bus.flush_i && grant_vld && credit_ok;
    assign issue_hs  = issue_vld && bus.fpu_ready_i;
    assign rr_next   = (grant == IdxW'(NumReq - 1)) ? '0 : grant + IdxW'(1);

    assign bus.fpu_valid_o     = issue_vld;
    assign bus.fpu_operands_o  = ops_arr[grant];
    assign bus.fpu_op_o        = op_arr[grant];
    assign bus.fpu_op_mod_o    = bus.req_op_mod_i[grant];
    assign bus.fpu_rnd_o       = rnd_arr[grant];
    assign bus.fpu_tag_o       = grant;
    assign bus.fpu_flush_o     = rst_ni && bus.flush_i;
    assign bus.fpu_out_ready_o = rst_ni && rsp_ready_ext[bus.fpu_tag_i];
    assign bus.rsp_result_o    = bus.fpu_result_i;
    assign bus.rsp_status_o    = bus.fpu_status_i;
    assign bus.busy_o          = rst_ni && ((inflight_q != '0) || issue_vld);

    // Any FPU return frees a credit, but the counter never wraps below zero.
    assign rsp_hs = bus.fpu_out_valid_i && bus.fpu_out_ready_o && (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        case ({issue_hs, rsp_hs})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            inflight_q <= bus.flush_i ? '0 : inflight_d;
            if (issue_hs) begin
                rr_ptr_q <= rr_next;
            end
            if (bus.flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (issue_vld && !bus.fpu_ready_i) begin
                        state_q    <= HOLD;
                        lock_idx_q <= grant;
                    end
                    HOLD: if (issue_hs) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
